conv3x3_window_gen: RTL and testbench
=====================================

// Module: conv3x3_window_gen
// PURPOSE
//   Streaming 3x3 window generator feeding conv3x3_multi_channel_core. Accepts one multi-channel
//   pixel per beat in raster order and buffers the two previous rows in line buffers.
//   Emits the full [NUM_CHANNELS][3][3] neighbourhood for every valid (unpadded) output position.
//   Output is registered with a 1-cycle latency, so it drops straight onto the core's data_in/valid_in.
// PARAMETERS
//   DATA_WIDTH    8  signed pixel width per channel
//   NUM_CHANNELS  3  channels per pixel
//   IMG_WIDTH     8  pixels per row (>=3)
//   IMG_HEIGHT    8  rows per frame (>=3)
// PORTS
//   clk         in   1                        single clock, rising edge
//   rst_n       in   1                        asynchronous, active-low reset
//   valid_in    in   1                        data_in holds a pixel this cycle
//   sof_in      in   1                        start of frame; qualified by valid_in
//   data_in     in   [NUM_CHANNELS] x DW s    one pixel, all channels
//   window_out  out  [NUM_CHANNELS][3][3] x DW s   window; [c][0][0] = top-left (oldest row/col)
//   valid_out   out  1                        window_out is valid this cycle
//   frame_done  out  1                        1-cycle pulse with the last window of a frame
// BEHAVIOUR
//   Reset (async, rst_n low)
//     - valid_out=0, frame_done=0, window_out=all 0.
//     - row/col counters=0; window shift registers=0.
//     - Line buffer contents need not be cleared.
//   Pixel acceptance
//     - Every cycle with valid_in=1 consumes a pixel. There is no backpressure.
//     - Cycles with valid_in=0 hold all state. valid_out=0 and frame_done=0 on the next edge.
//   Accepted pixel at (row r, col c)
//     - Window shifts left one column per channel.
//     - New right column = {linebuf1[c], linebuf0[c], data_in} for rows 0,1,2.
//     - linebuf1[c] <= linebuf0[c]; linebuf0[c] <= data_in. Reads use pre-update values.
//     - col increments. At col=IMG_WIDTH-1 it wraps to 0 and row increments.
//     - At (IMG_HEIGHT-1, IMG_WIDTH-1) both counters wrap to 0 (next frame).
//   Output
//     - Registered 1 cycle after acceptance: valid_out=1 iff r>=2 && c>=2.
//     - Then window_out[ch][i][j] = pixel(r-2+i, c-2+j, ch).
//     - window_out holds its last value when valid_out=0.
//     - Windows per frame = (IMG_HEIGHT-2)*(IMG_WIDTH-2). No padding.
//     - Columns 0 and 1 of each row produce no output, so stale cross-row data never escapes.
//   frame_done
//     - Asserted with valid_out for pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
//   sof_in
//     - With valid_in=1, the pixel is treated as (0,0) regardless of the counters.
//     - Counters are forced, then advance normally to (0,1).
//     - Ignored when valid_in=0.
//     - sof_in on a pixel where the counters are already (0,0) is a no-op.
//   Arithmetic
//     - None. Pure storage and routing; data is passed bit-exact.
//     - Counter widths are $clog2 of the image dimension.
//   Reset mid-frame
//     - Outputs clear immediately (asynchronous).
//     - After release, the first accepted pixel is (0,0). Any partial frame is discarded.
// TESTING
//   1. 8x8 frame, ch0=r*8+c, ch1=ch0+64, ch2=-ch0, continuous valid_in.
//      -> first valid_out one cycle after pixel (2,2), ch0 window {{0,1,2},{8,9,10},{16,17,18}},
//         ch2 negated; exactly 36 windows; frame_done together with window ch0 {{45..47},{53..55},{61..63}}.
//   2. Same frame, valid_in toggling 1/0 with random gaps of 0-3 cycles
//      -> identical 36-window sequence; valid_out never asserted on a gap cycle.
//   3. Two back-to-back frames, no idle cycle
//      -> 72 windows; second frame's first window is rows 0-2 of frame 2 only; two frame_done pulses.
//   4. Frame aborted after pixel (4,5), then sof_in with a new frame
//      -> no windows mixing old and new frame; 36 correct windows for the new frame.
//   5. rst_n low asynchronously mid-frame at pixel (3,3)
//      -> valid_out/window_out/frame_done 0 before the next edge; a clean frame after release matches test 1.
//   6. Output wired to conv3x3_multi_channel_core with all-ones kernels, bias 0
//      -> core result equals the sum of 27 window values; all-negative image -> result 0.

Source files
------------

// File: rtl/conv3x3_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_window_gen
// Description : Streaming 3x3 neighbourhood generator. Accepts one
//               multi-channel pixel per valid_in beat in raster order. Two
//               line buffers hold the previous two rows. For every unpadded
//               output position it presents the full [ch][3][3] window one
//               cycle after the pixel that completes it.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               valid_in   - data_in carries a pixel this cycle
//               sof_in     - start of frame, qualified by valid_in
//               data_in    - one pixel, [NUM_CHANNELS] x DATA_WIDTH
//               window_out - [ch][row][col], [ch][0][0] = oldest row/col
//               valid_out  - window_out valid this cycle
//               frame_done - pulse with the last window of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_window_gen #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            valid_in,
  input  logic                                            sof_in,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]         data_in,
  output logic [NUM_CHANNELS-1:0][2:0][2:0][DATA_WIDTH-1:0] window_out,
  output logic                                            valid_out,
  output logic                                            frame_done
);

  localparam int c_COL_W = $clog2(IMG_WIDTH);
  localparam int c_ROW_W = $clog2(IMG_HEIGHT);

  // Data is routed bit-exact, so signedness never matters inside the block.
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]            r_lb0 [IMG_WIDTH];
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]            r_lb1 [IMG_WIDTH];
  logic [NUM_CHANNELS-1:0][2:0][2:0][DATA_WIDTH-1:0]  r_win;
  logic [NUM_CHANNELS-1:0][2:0][2:0][DATA_WIDTH-1:0]  w_win_next;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]            w_lb0_rd;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]            w_lb1_rd;

  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;
  logic [c_COL_W-1:0] w_col;
  logic [c_ROW_W-1:0] w_row;
  logic [c_COL_W-1:0] w_col_next;
  logic [c_ROW_W-1:0] w_row_next;
  logic               w_win_valid;
  logic               w_last_pix;

  // sof_in overrides the counters for the pixel it arrives with, so the
  // pixel itself is handled as (0,0) and everything below uses w_row/w_col.
  assign w_col = sof_in ? '0 : r_col;
  assign w_row = sof_in ? '0 : r_row;

  assign w_lb0_rd = r_lb0[w_col];
  assign w_lb1_rd = r_lb1[w_col];

  assign w_win_valid = (w_row >= c_ROW_W'(2)) && (w_col >= c_COL_W'(2));
  assign w_last_pix  = (w_row == c_ROW_W'(IMG_HEIGHT-1)) &&
                       (w_col == c_COL_W'(IMG_WIDTH-1));

  always_comb begin
    w_col_next = w_col + c_COL_W'(1);
    w_row_next = w_row;
    if (w_col == c_COL_W'(IMG_WIDTH-1)) begin
      w_col_next = '0;
      w_row_next = (w_row == c_ROW_W'(IMG_HEIGHT-1)) ? '0 : w_row + c_ROW_W'(1);
    end
  end

  // Shift every row one column left and append the new right-hand column
  // taken from the two line buffers (pre-update) and the incoming pixel.
  always_comb begin
    w_win_next = r_win;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      for (int i = 0; i < 3; i++) begin
        w_win_next[ch][i][0] = r_win[ch][i][1];
        w_win_next[ch][i][1] = r_win[ch][i][2];
      end
      w_win_next[ch][0][2] = w_lb1_rd[ch];
      w_win_next[ch][1][2] = w_lb0_rd[ch];
      w_win_next[ch][2][2] = data_in[ch];
    end
  end

  // Line buffers carry no reset: columns 0/1 of each row never emit, so any
  // stale contents are flushed out of the window before they can be seen.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_win      <= '0;
      window_out <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        r_col <= w_col_next;
        r_row <= w_row_next;
        r_win <= w_win_next;
        if (w_win_valid) begin
          window_out <= w_win_next;
          valid_out  <= 1'b1;
          frame_done <= w_last_pix;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv3x3_window_gen
// Description : Scoreboard bench for conv3x3_window_gen. The driver pushes
//               the expected window for each pixel that completes one; a
//               monitor pops and compares whenever valid_out is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_window_gen;

  localparam int DW = 8;
  localparam int NC = 3;
  localparam int W  = 8;
  localparam int H  = 8;

  typedef logic [NC-1:0][DW-1:0]             pix_t;
  typedef logic [NC-1:0][2:0][2:0][DW-1:0]   win_t;
  typedef struct {
    win_t win;
    logic fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic valid_in;
  logic sof_in;
  pix_t data_in;
  win_t window_out;
  logic valid_out;
  logic frame_done;

  conv3x3_window_gen #(
    .DATA_WIDTH  (DW),
    .NUM_CHANNELS(NC),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .sof_in    (sof_in),
    .data_in   (data_in),
    .window_out(window_out),
    .valid_out (valid_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   fd_seen  = 0;
  int   win_cnt  = 0;
  logic last_vin = 1'b0;
  win_t first_win;
  win_t last_win;

  byte unsigned hand_first[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
  byte unsigned hand_last[9]  = '{45, 46, 47, 53, 54, 55, 61, 62, 63};

  function automatic pix_t pix_of(input int r, input int c, input int seed);
    logic [DW-1:0] b;
    b = DW'(r * 8 + c + seed);
    pix_of[0] = b;
    pix_of[1] = b + 8'd64;
    pix_of[2] = -b;
  endfunction

  function automatic win_t exp_win(input int r, input int c, input int seed);
    pix_t p;
    exp_win = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        p = pix_of(r - 2 + i, c - 2 + j, seed);
        for (int ch = 0; ch < NC; ch++) exp_win[ch][i][j] = p[ch];
      end
  endfunction

  always @(posedge clk) last_vin <= valid_in;

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!last_vin) begin
        checks++;
        if (valid_out) begin
          errors++;
          $display("FAIL gap_valid: valid_out=%b after idle cycle, required 0", valid_out);
        end
      end
      if (frame_done && !valid_out) begin
        checks++;
        errors++;
        $display("FAIL fd_alone: frame_done=1 with valid_out=0");
      end
      if (valid_out) begin
        if (win_cnt == 0) first_win = window_out;
        if (frame_done) begin
          last_win = window_out;
          fd_seen++;
        end
        win_cnt++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_window: got %h, none expected", window_out);
        end else begin
          e = q.pop_front();
          if (window_out !== e.win) begin
            errors++;
            $display("FAIL window: got %h required %h", window_out, e.win);
          end
          checks++;
          if (frame_done !== e.fd) begin
            errors++;
            $display("FAIL frame_done: got %b required %b", frame_done, e.fd);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_pix(input int r, input int c, input int seed, input bit sof);
    exp_t e;
    valid_in = 1'b1;
    sof_in   = sof;
    data_in  = pix_of(r, c, seed);
    if (r >= 2 && c >= 2) begin
      e.win = exp_win(r, c, seed);
      e.fd  = (r == H - 1 && c == W - 1);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sof_in   = 1'b0;
  endtask

  task automatic drive_frame(input int seed, input int last_idx, input int max_gap, input bit sof);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r * W + c <= last_idx) begin
          drive_pix(r, c, seed, sof && r == 0 && c == 0);
          if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
  endtask

  task automatic end_test(input string name, input int exp_fd, input int exp_wins);
    idle(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: %0d windows outstanding, required 0", name, q.size());
    end
    checks++;
    if (fd_seen != exp_fd) begin
      errors++;
      $display("FAIL %s_frame_done_count: got %0d required %0d", name, fd_seen, exp_fd);
    end
    checks++;
    if (win_cnt != exp_wins) begin
      errors++;
      $display("FAIL %s_window_count: got %0d required %0d", name, win_cnt, exp_wins);
    end
    q.delete();
    fd_seen = 0;
    win_cnt = 0;
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (valid_out !== 1'b0 || frame_done !== 1'b0 || window_out !== '0) begin
      errors++;
      $display("FAIL %s: valid_out=%b frame_done=%b window_out=%h, required all 0",
               name, valid_out, frame_done, window_out);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    data_in  = '0;
    #12;
    check_zero_outputs("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Test 1: continuous frame
    drive_frame(0, W * H - 1, 0, 1'b1);
    end_test("t1", 1, 36);
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (first_win[0][k / 3][k % 3] !== hand_first[k][DW-1:0]) begin
        errors++;
        $display("FAIL first_win_ch0[%0d]: got %0d required %0d", k,
                 first_win[0][k / 3][k % 3], hand_first[k]);
      end
      checks++;
      if (last_win[0][k / 3][k % 3] !== hand_last[k][DW-1:0]) begin
        errors++;
        $display("FAIL last_win_ch0[%0d]: got %0d required %0d", k,
                 last_win[0][k / 3][k % 3], hand_last[k]);
      end
    end
    checks++;
    if (first_win[2][2][2] !== 8'hEE || first_win[1][0][0] !== 8'd64) begin
      errors++;
      $display("FAIL first_win_ch12: ch2[2][2]=%h ch1[0][0]=%h, required ee and 40",
               first_win[2][2][2], first_win[1][0][0]);
    end

    // Test 2: same frame with random gaps
    drive_frame(0, W * H - 1, 3, 1'b1);
    end_test("t2", 1, 36);

    // Test 3: two back-to-back frames
    drive_frame(10, W * H - 1, 0, 1'b1);
    drive_frame(20, W * H - 1, 0, 1'b1);
    end_test("t3", 2, 72);

    // Test 4: abort after (4,5), restart with sof_in
    drive_frame(0, 4 * W + 5, 0, 1'b1);
    drive_frame(100, W * H - 1, 0, 1'b1);
    end_test("t4", 1, 52);

    // Test 5: asynchronous reset right after pixel (3,3)
    drive_frame(0, 3 * W + 3, 0, 1'b1);
    #5;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_frame(0, W * H - 1, 0, 1'b0);
    end_test("t5", 1, 44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
